// File: rtl/meta_info_streamer_pkg.sv
// -----------------------------------------------------------------------------
// meta_info_pkg
// Shared definitions for the meta-info streamer: FSM state encoding, project
// and string geometry, the two special characters, and the ROM address helper.
// -----------------------------------------------------------------------------
package meta_info_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RDY = 3'd1,
        FETCH    = 3'd2,
        CHECK    = 3'd3,
        SEND     = 3'd4,
        EOL      = 3'd5,
        FIN      = 3'd6
    } state_e;

    localparam int NUM_PROJ  = 64;
    localparam int MAX_CHARS = 63;
    localparam int IDX_W     = 6;
    localparam int ADDR_W    = 2 * IDX_W;

    localparam logic [7:0] CHAR_NUL = 8'h00;
    localparam logic [7:0] CHAR_LF  = 8'h0A;

    // Highest index each counter may reach; neither counter ever wraps.
    localparam logic [IDX_W-1:0] LAST_PROJ = IDX_W'(NUM_PROJ - 1);
    localparam logic [IDX_W-1:0] LAST_CHR  = IDX_W'(MAX_CHARS - 1);

    // ROM address layout: project index in the upper half, character below.
    function automatic logic [ADDR_W-1:0] make_addr(input logic [IDX_W-1:0] proj,
                                                    input logic [IDX_W-1:0] chr);
        return {proj, chr};
    endfunction

endpackage

// File: rtl/meta_info_streamer_uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// 8N1 serialiser: start bit 0, eight data bits LSB first, stop bit 1, each
// bit CLKS_PER_BIT clocks long. tx idles high.
//
// Ports
//   clock : rising-edge clock
//   reset : asynchronous active-low reset (tx forced high, counters cleared)
//   data  : byte to send, captured when send is accepted
//   send  : request; accepted only while idle=1
//   tx    : serial output
//   idle  : ready to accept a new byte
//
// idle rises during the final clock of the stop bit, so a byte offered in
// that cycle starts its start bit immediately after the full stop bit and
// consecutive frames abut with no extra idle time.
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       send,
    output logic       tx,
    output logic       idle
);

    localparam logic [7:0] CLK_LAST       = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] CLK_STOP_EARLY = 8'(CLKS_PER_BIT - 2);
    localparam logic [3:0] BIT_LAST_DATA  = 4'd8;
    localparam logic [3:0] BIT_STOP       = 4'd9;

    logic [7:0] shift_q,   shift_d;
    logic [7:0] clk_cnt_q, clk_cnt_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;   // 0 = start, 1..8 = data, 9 = stop
    logic       tx_q,      tx_d;
    logic       idle_q,    idle_d;

    // Next-state logic for the bit sequencer.
    always_comb begin
        shift_d   = shift_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        idle_d    = idle_q;
        if (idle_q) begin
            if (send) begin
                shift_d   = data;
                clk_cnt_d = 8'd0;
                bit_cnt_d = 4'd0;
                tx_d      = 1'b0;
                idle_d    = 1'b0;
            end else begin
                tx_d = 1'b1;
            end
        end else if ((bit_cnt_q == BIT_STOP) && (clk_cnt_q == CLK_STOP_EARLY)) begin
            // Last stop-bit clock follows: report idle now so a waiting
            // byte can be accepted exactly as the stop bit ends.
            clk_cnt_d = 8'd0;
            bit_cnt_d = 4'd0;
            tx_d      = 1'b1;
            idle_d    = 1'b1;
        end else if (clk_cnt_q != CLK_LAST) begin
            clk_cnt_d = clk_cnt_q + 8'd1;
        end else begin
            clk_cnt_d = 8'd0;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == BIT_LAST_DATA) begin
                tx_d = 1'b1;
            end else begin
                tx_d    = shift_q[0];
                shift_d = {1'b0, shift_q[7:1]};
            end
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_q   <= 8'd0;
            clk_cnt_q <= 8'd0;
            bit_cnt_q <= 4'd0;
            tx_q      <= 1'b1;
            idle_q    <= 1'b1;
        end else begin
            shift_q   <= shift_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            idle_q    <= idle_d;
        end
    end

    assign tx   = tx_q;
    assign idle = idle_q;

endmodule

// File: rtl/meta_info_streamer.sv
// -----------------------------------------------------------------------------
// meta_info_streamer
// On a start request, reads all 64 NUL-terminated project strings from the
// meta-info ROM and sends each one over a UART, followed by a newline.
//
// Ports
//   clock    : rising-edge clock
//   reset    : asynchronous active-low reset
//   start    : one-cycle request, honoured only while idle
//   ready    : ROM ready, sampled only before the first fetch
//   rom_addr : {proj_idx, chr_idx} to the ROM, registered
//   rom_data : ROM character, valid ROM_LATENCY cycles after rom_addr moves
//   tx       : UART 8N1 serial output, idle high
//   busy     : high from accepted start until done
//   done     : one-cycle pulse once the final newline has left the UART
//
// Strings longer than 63 characters are cut at index 62; index 63 is never
// addressed. The character byte is captured by the UART in the CHECK cycle,
// and the newline is launched in the same cycle the previous frame releases
// the UART, so frames inside one line abut except for the fetch gap.
// -----------------------------------------------------------------------------
module meta_info_streamer
    import meta_info_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int ROM_LATENCY  = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              ready,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] LAT_LAST = 3'(ROM_LATENCY - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  proj_q,  proj_d;
    logic [IDX_W-1:0]  chr_q,   chr_d;
    logic [2:0]        lat_q,   lat_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    logic [IDX_W-1:0]  proj_inc_s;
    logic [IDX_W-1:0]  chr_inc_s;
    logic              send_s;
    logic [7:0]        send_data_s;
    logic              uart_idle_s;
    logic              uart_tx_s;

    assign proj_inc_s = proj_q + 6'd1;
    assign chr_inc_s  = chr_q + 6'd1;

    // FSM next-state, counter and UART launch logic.
    always_comb begin
        state_d     = state_q;
        proj_d      = proj_q;
        chr_d       = chr_q;
        lat_d       = lat_q;
        addr_d      = addr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        send_s      = 1'b0;
        send_data_s = CHAR_LF;
        case (state_q)
            IDLE: begin
                if (start) begin
                    proj_d  = 6'd0;
                    chr_d   = 6'd0;
                    lat_d   = 3'd0;
                    addr_d  = 12'd0;
                    busy_d  = 1'b1;
                    state_d = WAIT_RDY;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            WAIT_RDY: begin
                if (ready) begin
                    addr_d  = make_addr(proj_q, chr_q);
                    lat_d   = 3'd0;
                    state_d = FETCH;
                end else begin
                    state_d = WAIT_RDY;
                end
            end
            FETCH: begin
                if (lat_q == LAT_LAST) begin
                    lat_d   = 3'd0;
                    state_d = CHECK;
                end else begin
                    lat_d   = lat_q + 3'd1;
                end
            end
            CHECK: begin
                // The UART is always idle here: every path into FETCH first
                // waits for the previous frame to finish.
                send_s = 1'b1;
                if (rom_data == CHAR_NUL) begin
                    send_data_s = CHAR_LF;
                    state_d     = EOL;
                end else begin
                    send_data_s = rom_data;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (uart_idle_s) begin
                    if (chr_q == LAST_CHR) begin
                        send_s      = 1'b1;
                        send_data_s = CHAR_LF;
                        state_d     = EOL;
                    end else begin
                        chr_d   = chr_inc_s;
                        addr_d  = make_addr(proj_q, chr_inc_s);
                        lat_d   = 3'd0;
                        state_d = FETCH;
                    end
                end else begin
                    state_d = SEND;
                end
            end
            EOL: begin
                if (uart_idle_s) begin
                    chr_d = 6'd0;
                    if (proj_q == LAST_PROJ) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = FIN;
                    end else begin
                        proj_d  = proj_inc_s;
                        addr_d  = make_addr(proj_inc_s, 6'd0);
                        lat_d   = 3'd0;
                        state_d = FETCH;
                    end
                end else begin
                    state_d = EOL;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // FSM, index, latency and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            proj_q  <= 6'd0;
            chr_q   <= 6'd0;
            lat_q   <= 3'd0;
            addr_q  <= 12'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            proj_q  <= proj_d;
            chr_q   <= chr_d;
            lat_q   <= lat_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clock (clock),
        .reset (reset),
        .data  (send_data_s),
        .send  (send_s),
        .tx    (uart_tx_s),
        .idle  (uart_idle_s)
    );

    assign rom_addr = addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign tx       = uart_tx_s;

endmodule

// File: tb/tb_meta_info_streamer.sv
// -----------------------------------------------------------------------------
// tb_meta_info_streamer
// Directed runs against a latency-accurate ROM model. Expected bytes are
// queued from the ROM contents before each start; a UART decoder pops and
// compares every frame it receives and checks the bit-cell timing.
// -----------------------------------------------------------------------------
module tb_meta_info_streamer;

    localparam int CPB = 8;
    localparam int LAT = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        ready = 1'b0;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data;
    logic        tx;
    logic        busy;
    logic        done;

    meta_info_streamer #(
        .CLKS_PER_BIT(CPB),
        .ROM_LATENCY (LAT)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .ready   (ready),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clock = ~clock;

    // ROM model: data for an address appears LAT cycles after it is driven.
    logic [7:0] rom_mem  [0:4095];
    logic [7:0] rom_pipe [0:LAT-1];
    always @(posedge clock) begin
        rom_pipe[0] <= rom_mem[rom_addr];
        for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_pipe[LAT-1];

    int         n_vec    = 0;
    int         n_fail   = 0;
    int         done_cnt = 0;
    int         seen55   = 0;
    logic       busy_prev = 1'b0;
    logic       addr_bad  = 1'b0;
    logic [7:0] sb_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected stream: each project's characters up to NUL or 63 chars, then LF.
    task automatic build_expected();
        logic [11:0] a;
        sb_q.delete();
        for (int p = 0; p < 64; p++) begin
            for (int c = 0; c < 63; c++) begin
                a = {p[5:0], c[5:0]};
                if (rom_mem[a] == 8'h00) break;
                sb_q.push_back(rom_mem[a]);
            end
            sb_q.push_back(8'h0A);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) rom_mem[i] = 8'h00;
    endtask

    task automatic pulse_start();
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int base;
        int n;
        base = done_cnt;
        n = 0;
        while (done_cnt == base && n < budget) begin
            @(posedge clock); #2;
            n++;
        end
        check("done_within_budget", 32'(done_cnt != base), 32'd1);
        repeat (40) @(posedge clock);
        #2;
        check("done_pulse_count", 32'(done_cnt - base), 32'd1);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        check("idle_busy_low", 32'(busy), 32'd0);
        check("idle_tx_high", 32'(tx), 32'd1);
    endtask

    // UART decoder / scoreboard monitor.
    initial begin : uart_mon
        logic [7:0] byte_v;
        logic       cell_ok;
        logic       aborted;
        logic       v0;
        logic [7:0] exp_v;
        v0 = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (reset === 1'b1 && tx === 1'b0) begin
                aborted = 1'b0;
                cell_ok = 1'b1;
                byte_v  = 8'h00;
                for (int c = 0; c < 10 && !aborted; c++) begin
                    for (int k = 0; k < CPB && !aborted; k++) begin
                        if (!(c == 0 && k == 0)) begin
                            @(posedge clock); #1;
                        end
                        if (reset !== 1'b1) begin
                            aborted = 1'b1;
                        end else if (k == 0) begin
                            v0 = tx;
                        end else if (tx !== v0) begin
                            cell_ok = 1'b0;
                        end
                    end
                    if (c >= 1 && c <= 8) byte_v[c-1] = v0;
                    else if (c == 0 && v0 !== 1'b0) cell_ok = 1'b0;
                    else if (c == 9 && v0 !== 1'b1) cell_ok = 1'b0;
                end
                if (!aborted) begin
                    check("frame_timing", 32'(cell_ok), 32'd1);
                    if (byte_v == 8'h55 && cell_ok) seen55++;
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got 0x%0h with none expected at %0t", byte_v, $time);
                    end else begin
                        exp_v = sb_q.pop_front();
                        check("tx_byte", 32'(byte_v), 32'(exp_v));
                    end
                end
            end
        end
    end

    // Control monitor: done/busy relation and forbidden ROM addresses.
    initial begin : ctl_mon
        forever begin
            @(posedge clock); #1;
            if (done === 1'b1) begin
                done_cnt++;
                check("busy_falls_with_done", 32'({busy_prev, busy}), 32'b10);
            end
            if (rom_addr[5:0] === 6'd63) addr_bad = 1'b1;
            busy_prev = busy;
        end
    end

    initial begin : main
        int n;
        int bad;
        clear_rom();
        ready = 1'b1;
        repeat (3) @(posedge clock);
        #2;
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_rom_addr", 32'(rom_addr), 32'd0);

        // Run 1: "AB" in project 0, all others empty; second start ignored.
        rom_mem[12'h000] = 8'h41;
        rom_mem[12'h001] = 8'h42;
        build_expected();
        @(negedge clock); reset = 1'b1; start = 1'b1;
        @(posedge clock); #2;
        check("start_first_edge", 32'(busy), 32'd1);
        @(negedge clock); start = 1'b0;
        repeat (400) @(posedge clock);
        pulse_start();
        #2;
        check("busy_through_restart", 32'(busy), 32'd1);
        wait_done(20000);

        // Run 2: ready held low, 63 'x' in project 5, 0x55 in project 7.
        clear_rom();
        for (int c = 0; c < 64; c++) rom_mem[{6'd5, c[5:0]}] = 8'h78;
        rom_mem[{6'd7, 6'd0}] = 8'h55;
        build_expected();
        addr_bad = 1'b0;
        seen55   = 0;
        ready    = 1'b0;
        pulse_start();
        bad = 0;
        repeat (100) begin
            @(posedge clock); #2;
            if (tx !== 1'b1 || rom_addr !== 12'd0) bad++;
        end
        check("ready_low_hold", 32'(bad), 32'd0);
        check("ready_low_busy", 32'(busy), 32'd1);
        @(negedge clock); ready = 1'b1;
        n = 0;
        do begin
            @(posedge clock); #2;
            n++;
        end while (tx !== 1'b0 && n < 50);
        check("ready_to_first_bit", 32'(n), 32'(LAT + 2));
        repeat (200) @(posedge clock);
        @(negedge clock); ready = 1'b0;
        wait_done(30000);
        check("no_chr63_address", 32'(addr_bad), 32'd0);
        check("frame_0x55_seen", 32'(seen55), 32'd1);
        ready = 1'b1;

        // Run 3: reset in the third data bit of the first frame, then restart.
        clear_rom();
        rom_mem[12'h000] = 8'h41;
        rom_mem[12'h001] = 8'h42;
        build_expected();
        pulse_start();
        n = 0;
        do begin
            @(posedge clock); #2;
            n++;
        end while (tx !== 1'b0 && n < 100);
        check("first_frame_started", 32'(tx), 32'd0);
        repeat (26) @(posedge clock);
        #3;
        check("tx_low_before_reset", 32'(tx), 32'd0);
        reset = 1'b0;
        #1;
        check("reset_tx_async", 32'(tx), 32'd1);
        check("reset_busy_async", 32'(busy), 32'd0);
        sb_q.delete();
        repeat (3) @(posedge clock);
        #2;
        check("reset_hold_addr", 32'(rom_addr), 32'd0);
        check("reset_hold_tx", 32'(tx), 32'd1);
        @(negedge clock); reset = 1'b1;
        build_expected();
        pulse_start();
        wait_done(20000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/meta_info_streamer.md
META_INFO_STREAMER -- requirements
Module: meta_info_streamer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 8: clock cycles per UART bit, legal range 2..255.
REQ-002 Parameter ROM_LATENCY, default 3: cycles from rom_addr change to valid rom_data, legal range 1..7.
REQ-003 Port clock, input, 1: sole clock, rising-edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: single-cycle request to dump all 64 project strings.
REQ-006 Port ready, input, 1: meta-info ROM is ready to be addressed.
REQ-007 Port rom_addr, output, 12: {proj_idx[5:0], chr_idx[5:0]} to the meta-info ROM.
REQ-008 Port rom_data, input, 8: ASCII character returned by the ROM; 0x00 terminates a string.
REQ-009 Port tx, output, 1: UART 8N1 serial output, idle high.
REQ-010 Port busy, output, 1: high from accepted start until done.
REQ-011 Port done, output, 1: one-cycle pulse when the last newline's stop bit completes.

Function
REQ-012 The block SHALL use the FSM states IDLE, WAIT_RDY, FETCH, CHECK, SEND, EOL and FIN.
REQ-013 IDLE: on start=1, the block SHALL clear proj_idx and chr_idx, assert busy, and go to WAIT_RDY. start SHALL be ignored in every other state.
REQ-014 WAIT_RDY: the block SHALL hold until ready=1, then go to FETCH.
REQ-015 FETCH: the block SHALL drive rom_addr={proj_idx,chr_idx} and count exactly ROM_LATENCY cycles, then go to CHECK.
REQ-016 CHECK: if rom_data==0x00, the block SHALL go to EOL; otherwise it SHALL latch rom_data and go to SEND.
REQ-017 SEND: the block SHALL transmit the latched byte via uart_tx.
REQ-018 On the completion of SEND, if chr_idx==62 the block SHALL go to EOL; otherwise it SHALL increment chr_idx and go to FETCH.
REQ-019 EOL: the block SHALL transmit 0x0A, then clear chr_idx.
REQ-020 After EOL, if proj_idx==63 the block SHALL go to FIN; otherwise it SHALL increment proj_idx and go to FETCH.
REQ-021 FIN: the block SHALL pulse done for one cycle, deassert busy in the same cycle, and return to IDLE.
REQ-022 chr_idx and proj_idx SHALL be 6-bit values. They SHALL never wrap during operation: chr_idx stops at 62 and proj_idx stops at 63.
REQ-023 A string of 63 non-NUL characters SHALL be sent in full, followed by 0x0A, with no NUL read for index 63.
REQ-024 UART frame format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit SHALL last exactly CLKS_PER_BIT cycles.
REQ-025 Back-to-back frames SHALL have no extra idle bit between them, apart from the FETCH/CHECK gap.
REQ-026 rom_addr SHALL hold its value while in SEND and EOL.
REQ-027 If ready falls after WAIT_RDY, the block SHALL ignore it; ready is sampled only in WAIT_RDY.

Reset
REQ-028 While reset=0, the block SHALL force: state=IDLE, tx=1, busy=0, done=0, rom_addr=0, both indices=0 and the uart_tx counters=0.
REQ-029 A reset asserted mid-frame SHALL drive tx high asynchronously; no partial frame SHALL resume after reset is released.
REQ-030 After reset is released, the first accepted start SHALL be the one sampled on or after the first rising clock edge.

Structure
REQ-031 Package meta_info_pkg SHALL hold the state enum, NUM_PROJ=64, MAX_CHARS=63, CHAR_NUL=8'h00 and CHAR_LF=8'h0A.
REQ-032 UART serialisation SHALL be a sub-module uart_tx with ports clock, reset, data[7:0], send, tx and idle. send is accepted only when idle=1.
REQ-033 The top level SHALL contain only the FSM, the index counters and the latency counter.

Verification
REQ-034 Scenario: reset asserted with a ROM model where proj 0 = "AB\0" and all other projects are empty; pulse start -> the decoded tx stream starts "A","B",0x0A, then 63 further 0x0A bytes; done pulses once; busy falls in the same cycle as done.
REQ-035 Scenario: proj 5 holds 63 chars of 'x' with no NUL -> the bench sees 63 'x' then 0x0A for proj 5, and rom_addr never equals {6'd5,6'd63}.
REQ-036 Scenario: ready held at 0 for 100 cycles after start -> tx stays 1 and rom_addr stays 0 throughout; streaming starts within ROM_LATENCY+2 cycles after ready rises.
REQ-037 Scenario: CLKS_PER_BIT=8, byte 0x55 -> the bit cells are 8 cycles each, in the order 0,1,0,1,0,1,0,1,0,1; the frame lasts 80 cycles.
REQ-038 Scenario: reset pulsed low during the 3rd data bit of a frame -> tx goes to 1 in the same cycle; busy=0; a new start restarts at proj 0, chr 0.
REQ-039 Scenario: start pulsed again while busy -> no effect; the total output is still exactly 64 newline-terminated lines.
